hazard_ctrl: RTL
================

# hazard_ctrl

Parametrised pipeline hazard controller for the 5-stage core, sitting beside the pipeline registers and driving their enables.
- Unifies three stall sources: multi-cycle execution units in EX (N_MC units, start/busy handshake with watchdog), load-use interlock between ID and EX, and a configurable branch fetch penalty.
- Produces per-stage enables, an ID/EX bubble-insert strobe and a fetch-bubble request.

## Interface
- N_MC, 2: number of multi-cycle EX units (index 0 = divider, 1 = multiplier).
- BR_PENALTY, 2: fetch-bubble cycles per branch/jump decoded in ID (≥1).
- MC_TIMEOUT, 64: maximum WAIT cycles before watchdog release (≥2).
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- ID_rs1_idx, ID_rs2_idx  in  5 each  source register indices in ID.
- ID_rs1_used, ID_rs2_used  in  1 each  source actually read.
- ID_is_branch  in  1  branch/jump in ID.
- ID_EX_valid  in  1  ID/EX holds a real instruction.
- ID_EX_is_load  in  1  instruction in EX is a load.
- ID_EX_rd_idx  in  5  destination of instruction in EX.
- ID_EX_mc_sel  in  N_MC  unit request of instruction in EX.
- EX_mc_busy  in  N_MC  per-unit busy.
- ST_pc_en, ST_if_id_en, ST_id_ex_en, ST_ex_mem_en, ST_mem_wb_en  out  1 each  register enables.
- ST_id_ex_bubble  out  1  load NOP into ID/EX this edge.
- ST_br_stall  out  1  fetch injects NOP into IF/ID.
- ST_mc_start  out  N_MC  one-cycle start pulse to selected unit.
- ST_mc_timeout  out  1  sticky watchdog error.

## Operation
- MC FSM, states IDLE, ISSUE, WAIT:
  - Selected unit = lowest set bit of ID_EX_mc_sel; only that bit is used.
  - IDLE: if ID_EX_valid & |ID_EX_mc_sel, assert ST_mc_start for the selected unit, latch the selection, go ISSUE.
  - ISSUE: the unit asserts busy the following cycle; go WAIT unconditionally. Clear the watchdog counter.
  - WAIT: if busy of the latched unit is high, increment the watchdog counter. When busy is low, or the counter reaches MC_TIMEOUT, go IDLE.
  - If released by the watchdog while busy is still high, set ST_mc_timeout; it clears only on rst.
- freeze = (IDLE & start condition) | ISSUE | (WAIT & latched busy & counter < MC_TIMEOUT).
  - With busy low in WAIT, freeze = 0: the result is captured into EX/MEM that edge and ID/EX advances.
  - IDLE therefore never re-starts the same instruction.
- Load-use: lu = ID_EX_valid & ID_EX_is_load & ID_EX_rd_idx≠0 & ((ID_rs1_used & rs1==rd) | (ID_rs2_used & rs2==rd)).
- Priority and outputs:
  - freeze: all five enables 0, bubble 0.
  - else lu: ST_pc_en = ST_if_id_en = 0; ST_id_ex_en = 1 with ST_id_ex_bubble = 1; ST_ex_mem_en = ST_mem_wb_en = 1.
  - else: all enables 1, bubble 0.
- Branch counter, width $clog2(BR_PENALTY):
  - ST_br_stall = ID_is_branch | (cnt≠0).
  - Load cnt = BR_PENALTY−1 on an edge where ID_is_branch & ST_if_id_en.
  - Else decrement when cnt≠0 & ~freeze.
  - A branch held in ID by lu or freeze keeps ST_br_stall high and does not load the counter until it leaves ID.
  - cnt≠0 with a new ID_is_branch cannot occur, since ID holds bubbles; the load takes precedence regardless.

## Timing
- Reset: FSM IDLE, cnt 0, watchdog 0, ST_mc_timeout 0.
  - While rst=1, outputs are forced: enables 1, bubble 0, ST_br_stall 0, ST_mc_start 0.
- All outputs are combinational from current state and inputs; no input-to-output register latency.
- MC op with unit busy for B cycles (busy high cycles 2..B+1 after start):
  - Freeze lasts from the start cycle through the last busy cycle, B+2 cycles total.
  - The pipeline advances on the first cycle busy is low in WAIT.
- Load-use costs exactly 1 bubble.
- Each branch costs BR_PENALTY fetch bubbles, plus cycles during which the pipeline is frozen.
- rst mid-operation: abandons MC wait and branch count next edge; no start pulse is re-issued.

## Test plan
- Divider (sel=01), busy high 4 cycles:
  - ST_mc_start=01 for exactly one cycle.
  - All enables 0 for 6 cycles, then 1.
  - ST_mc_timeout stays 0.
- ID_EX load rd=5, ID rs2=5, rs2_used=1 → one cycle with pc_en=if_id_en=0, bubble=1, id_ex/ex_mem/mem_wb_en=1. Same stimulus with rd=0 → no stall.
- BR_PENALTY=3, branch in ID with no other hazard → ST_br_stall high 3 consecutive cycles, then 0.
- Branch in ID together with a load-use hit:
  - Cycle 1: lu stall and br_stall=1.
  - Then 3 further br_stall cycles.
  - Counter loads only on the edge the branch leaves ID.
- MC_TIMEOUT=8, multiplier busy stuck high:
  - Freeze releases after 10 cycles.
  - ST_mc_timeout=1 and stays set until rst.
- ID_EX_mc_sel=11 → only ST_mc_start[0] pulses. Assert rst during WAIT → next cycle all enables 1 and FSM IDLE.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: merges multi-cycle EX unit freezes, load-use interlock
// and branch fetch penalty into per-stage register enables and bubble strobes.
module hazard_ctrl #(
   parameter int N_MC       = 2,
   parameter int BR_PENALTY = 2,
   parameter int MC_TIMEOUT = 64
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [4:0]      ID_rs1_idx,
   input  logic [4:0]      ID_rs2_idx,
   input  logic            ID_rs1_used,
   input  logic            ID_rs2_used,
   input  logic            ID_is_branch,
   input  logic            ID_EX_valid,
   input  logic            ID_EX_is_load,
   input  logic [4:0]      ID_EX_rd_idx,
   input  logic [N_MC-1:0] ID_EX_mc_sel,
   input  logic [N_MC-1:0] EX_mc_busy,
   output logic            ST_pc_en,
   output logic            ST_if_id_en,
   output logic            ST_id_ex_en,
   output logic            ST_ex_mem_en,
   output logic            ST_mem_wb_en,
   output logic            ST_id_ex_bubble,
   output logic            ST_br_stall,
   output logic [N_MC-1:0] ST_mc_start,
   output logic            ST_mc_timeout,
   output logic [1:0]      dbg_mc_state
);

   localparam int BW = (BR_PENALTY > 1) ? $clog2(BR_PENALTY) : 1;
   localparam int WW = $clog2(MC_TIMEOUT + 1);

   // Encoding is visible on dbg_mc_state: 0 = IDLE, 1 = ISSUE, 2 = WAIT.
   typedef enum logic [1:0] {
      MC_IDLE  = 2'd0,
      MC_ISSUE = 2'd1,
      MC_WAIT  = 2'd2
   } mc_state_t;

   mc_state_t       state_q, state_d;
   logic [N_MC-1:0] sel_q, sel_d, sel_first, start_raw;
   logic [WW-1:0]   wd_q, wd_d;
   logic            timeout_q, timeout_d;
   logic [BW-1:0]   br_cnt_q;
   logic            start_cond, lat_busy, wd_expired, freeze, lu;

   // Only the lowest requested unit is honoured.
   assign sel_first  = ID_EX_mc_sel & (~ID_EX_mc_sel + N_MC'(1));
   assign start_cond = ID_EX_valid & (|ID_EX_mc_sel);
   assign lat_busy   = |(EX_mc_busy & sel_q);
   assign wd_expired = (wd_q == WW'(MC_TIMEOUT));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= MC_IDLE;
         sel_q     <= '0;
         wd_q      <= '0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         sel_q     <= sel_d;
         wd_q      <= wd_d;
         timeout_q <= timeout_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      sel_d     = sel_q;
      wd_d      = wd_q;
      timeout_d = timeout_q;
      freeze    = 1'b0;
      start_raw = '0;
      case (state_q)
         MC_IDLE: begin
            if (start_cond) begin
               freeze    = 1'b1;
               start_raw = sel_first;
               sel_d     = sel_first;
               state_d   = MC_ISSUE;
            end
         end
         MC_ISSUE: begin
            freeze  = 1'b1;
            wd_d    = '0;
            state_d = MC_WAIT;
         end
         MC_WAIT: begin
            if (lat_busy && !wd_expired) begin
               freeze = 1'b1;
               wd_d   = wd_q + WW'(1);
            end else begin
               // Busy low: result is captured this edge. Busy high: watchdog release.
               state_d = MC_IDLE;
               if (lat_busy) timeout_d = 1'b1;
            end
         end
         default: state_d = MC_IDLE;
      endcase
   end

   assign lu = ID_EX_valid & ID_EX_is_load & (ID_EX_rd_idx != 5'd0) &
               ((ID_rs1_used & (ID_rs1_idx == ID_EX_rd_idx)) |
                (ID_rs2_used & (ID_rs2_idx == ID_EX_rd_idx)));

   always_comb begin
      ST_pc_en        = 1'b1;
      ST_if_id_en     = 1'b1;
      ST_id_ex_en     = 1'b1;
      ST_ex_mem_en    = 1'b1;
      ST_mem_wb_en    = 1'b1;
      ST_id_ex_bubble = 1'b0;
      ST_br_stall     = 1'b0;
      ST_mc_start     = '0;
      if (!rst) begin
         ST_br_stall = ID_is_branch | (br_cnt_q != '0);
         ST_mc_start = start_raw;
         if (freeze) begin
            ST_pc_en     = 1'b0;
            ST_if_id_en  = 1'b0;
            ST_id_ex_en  = 1'b0;
            ST_ex_mem_en = 1'b0;
            ST_mem_wb_en = 1'b0;
         end else if (lu) begin
            ST_pc_en        = 1'b0;
            ST_if_id_en     = 1'b0;
            ST_id_ex_bubble = 1'b1;
         end
      end
   end

   // Counter loads only when the branch actually leaves ID.
   always_ff @(posedge clk) begin
      if (rst) begin
         br_cnt_q <= '0;
      end else if (ID_is_branch && ST_if_id_en) begin
         br_cnt_q <= BW'(BR_PENALTY - 1);
      end else if ((br_cnt_q != '0) && !freeze) begin
         br_cnt_q <= br_cnt_q - BW'(1);
      end
   end

   assign ST_mc_timeout = timeout_q;
   assign dbg_mc_state  = state_q;

endmodule
